implication_trail_writer: RTL

- Write-side counterpart of the BCP conflict-analysis path.
- Records each implication from the BCP processing elements: variable, value, antecedent (reason) mask and decision level.
- Stores these into per-variable reason/level storage and a chronological trail stack.
- Exposes an asynchronous read port the conflict analysis logic addresses by variable index, and performs non-chronological backtrack by popping the trail down to a target level.

---
 rtl/implication_trail_writer_if.sv | 37 +++
 rtl/implication_trail_writer.sv | 114 +++++++++++
 2 files changed

// File: rtl/implication_trail_writer_if.sv
// Bundles the implication, backtrack and conflict-analysis read signals of the trail writer.
// The slave modport is the writer; the master modport is the BCP/analysis side.
interface implication_trail_writer_if #(
    parameter int unsigned VAR_NUM = 8,
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned ADDR_W  = $clog2(VAR_NUM)
);
    logic               imp_valid;
    logic               imp_ready;
    logic [ADDR_W-1:0]  imp_var;
    logic               imp_value;
    logic [VAR_NUM-1:0] imp_reason;
    logic [LEVEL_W-1:0] imp_level;
    logic               bt_req;
    logic [LEVEL_W-1:0] bt_level;
    logic               bt_done;
    logic [ADDR_W-1:0]  rd_addr;
    logic [VAR_NUM-1:0] rd_reason;
    logic [LEVEL_W-1:0] rd_level;
    logic               rd_assigned;
    logic [VAR_NUM-1:0] assigned_mask;
    logic [VAR_NUM-1:0] assignment;
    logic [ADDR_W:0]    trail_count;
    logic               dup_err;

    modport slave (
        input  imp_valid, imp_var, imp_value, imp_reason, imp_level, bt_req, bt_level, rd_addr,
        output imp_ready, bt_done, rd_reason, rd_level, rd_assigned, assigned_mask, assignment,
               trail_count, dup_err
    );

    modport master (
        output imp_valid, imp_var, imp_value, imp_reason, imp_level, bt_req, bt_level, rd_addr,
        input  imp_ready, bt_done, rd_reason, rd_level, rd_assigned, assigned_mask, assignment,
               trail_count, dup_err
    );
endinterface

// File: rtl/implication_trail_writer.sv
// Records BCP implications into per-variable reason/level storage and a chronological trail,
// and unwinds the trail one entry per cycle down to a target decision level.
module implication_trail_writer #(
    parameter int unsigned VAR_NUM = 8,
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned ADDR_W  = $clog2(VAR_NUM)
) (
    input logic                       clk,
    input logic                       rst,
    implication_trail_writer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBacktrack, StDone} state_t;

    localparam logic [ADDR_W:0] CountMax = (ADDR_W+1)'(VAR_NUM);
    localparam logic [ADDR_W:0] CountOne = (ADDR_W+1)'(1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_trail  [VAR_NUM];
    logic [VAR_NUM-1:0] r_reason [VAR_NUM];
    logic [LEVEL_W-1:0] r_level  [VAR_NUM];
    logic [VAR_NUM-1:0] r_assigned;
    logic [VAR_NUM-1:0] r_assignment;
    logic [ADDR_W:0]    r_count;
    logic [LEVEL_W-1:0] r_bt_level;
    logic               r_dup_err;
    logic               r_bt_done;

    logic              w_imp_ready;
    logic              w_accept;
    logic              w_imp_in_range;
    logic              w_imp_new;
    logic              w_rd_in_range;
    logic [ADDR_W:0]   w_top_idx;
    logic [ADDR_W-1:0] w_top_var;
    logic              w_pop;

    assign w_imp_ready    = (r_state == StIdle) && !bus.bt_req && (r_count < CountMax);
    assign w_accept       = bus.imp_valid && w_imp_ready;
    assign w_imp_in_range = {1'b0, bus.imp_var} < CountMax;
    assign w_imp_new      = w_imp_in_range && !r_assigned[bus.imp_var];

    // Top-of-trail lookup wraps harmlessly when empty; w_pop is gated on a non-zero count.
    assign w_top_idx = r_count - CountOne;
    assign w_top_var = r_trail[w_top_idx[ADDR_W-1:0]];
    assign w_pop     = (r_count != '0) && (r_level[w_top_var] > r_bt_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_assigned   <= '0;
            r_assignment <= '0;
            r_count      <= '0;
            r_bt_level   <= '0;
            r_dup_err    <= 1'b0;
            r_bt_done    <= 1'b0;
            for (int unsigned i = 0; i < VAR_NUM; i++) begin
                r_trail[i]  <= '0;
                r_reason[i] <= '0;
                r_level[i]  <= '0;
            end
        end else begin
            r_bt_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.bt_req) begin
                        r_bt_level <= bus.bt_level;
                        r_state    <= StBacktrack;
                    end else if (w_accept) begin
                        if (w_imp_new) begin
                            r_trail[r_count[ADDR_W-1:0]] <= bus.imp_var;
                            r_reason[bus.imp_var]        <= bus.imp_reason;
                            r_level[bus.imp_var]         <= bus.imp_level;
                            r_assigned[bus.imp_var]      <= 1'b1;
                            r_assignment[bus.imp_var]    <= bus.imp_value;
                            r_count                      <= r_count + CountOne;
                        end else begin
                            r_dup_err <= 1'b1;
                        end
                    end
                end
                StBacktrack: begin
                    if (w_pop) begin
                        r_assigned[w_top_var]   <= 1'b0;
                        r_assignment[w_top_var] <= 1'b0;
                        r_reason[w_top_var]     <= '0;
                        r_level[w_top_var]      <= '0;
                        r_count                 <= w_top_idx;
                    end else begin
                        r_state   <= StDone;
                        r_bt_done <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_rd_in_range = {1'b0, bus.rd_addr} < CountMax;

    assign bus.imp_ready     = w_imp_ready;
    assign bus.bt_done       = r_bt_done;
    assign bus.rd_reason     = w_rd_in_range ? r_reason[bus.rd_addr] : '0;
    assign bus.rd_level      = w_rd_in_range ? r_level[bus.rd_addr] : '0;
    assign bus.rd_assigned   = w_rd_in_range ? r_assigned[bus.rd_addr] : 1'b0;
    assign bus.assigned_mask = r_assigned;
    assign bus.assignment    = r_assignment;
    assign bus.trail_count   = r_count;
    assign bus.dup_err       = r_dup_err;
endmodule
